sgd_x_wb_burst_writer: RTL and testbench
========================================

SGD_X_WB_BURST_WRITER -- requirements
Module: sgd_x_wb_burst_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, meaning the host byte-address width.
REQ-002 SHALL have parameter FIFO_DEPTH_BITS, default 6, meaning log2 of the data FIFO depth in 512-bit lines.
REQ-003 SHALL have parameter AF_MARGIN, default 20, meaning the free-line threshold for almost_full; it covers the upstream in-flight pipeline.
REQ-004 SHALL have parameter MAX_BURST_BYTES, default 4096, meaning the maximum bytes per emitted write command.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 x_data_send_back_start  in  1  level from upstream; a rising edge launches one epoch write-back.
REQ-008 x_data_send_back_addr  in  64  host byte base address, 64-byte aligned; sampled on the start edge.
REQ-009 x_data_send_back_length  in  32  total bytes, multiple of 64; sampled on the start edge.
REQ-010 x_data_out  in  512  upstream data line.
REQ-011 x_data_out_valid  in  1  line valid; it has no ready and is always accepted.
REQ-012 x_data_out_almost_full  out  1  backpressure to upstream.
REQ-013 mem_wr_cmd_valid / mem_wr_cmd_ready  out/in  1/1  write-command handshake.
REQ-014 mem_wr_cmd_addr / mem_wr_cmd_len  out  64/32  burst byte address and byte length.
REQ-015 mem_wr_data / mem_wr_data_valid / mem_wr_data_ready / mem_wr_data_last  out/out/in/out  512/1/1/1  write-data stream.
REQ-016 x_wb_done  out  1  one-cycle pulse when an epoch write-back completes.
REQ-017 x_wb_error  out  1  sticky error flag.
REQ-018 x_wb_stat_bursts / x_wb_stat_lines  out  32/32  statistics counters.

Function
REQ-019 SHALL implement FSM states IDLE, CMD, DATA, DONE.
REQ-020 In IDLE, a rising edge of start SHALL latch addr and length into cur_addr and remaining, then move to CMD. If the latched length is 0, the FSM SHALL go to DONE instead.
REQ-021 In CMD, burst length SHALL be min(remaining, MAX_BURST_BYTES, 4096 - cur_addr[11:0]), so no burst crosses a 4 KB boundary.
REQ-022 In CMD, mem_wr_cmd_valid SHALL stay high with address and length stable until ready. On the handshake the FSM SHALL move to DATA.
REQ-023 In DATA, the block SHALL forward FIFO lines with valid/ready semantics: beats = burst_len/64, and last is asserted on the final beat.
REQ-024 After the last beat is accepted:
- cur_addr += burst_len and remaining -= burst_len;
- if remaining becomes 0, go to DONE, else go to CMD.
REQ-025 DONE SHALL pulse x_wb_done for one cycle, then return to IDLE.
REQ-026 Data MAY arrive before or during the command phase. The FIFO SHALL buffer it, and mem_wr_data_valid SHALL be asserted only when the FIFO is non-empty and the FSM is in DATA.
REQ-027 almost_full SHALL be registered, and high when FIFO occupancy >= 2^FIFO_DEPTH_BITS - AF_MARGIN.
REQ-028 A write while the FIFO is full SHALL drop the line and set x_wb_error.
REQ-029 A start rising edge while not in IDLE SHALL be ignored and SHALL set x_wb_error.
REQ-030 A length not a multiple of 64, or an address not 64-aligned, SHALL set x_wb_error. The write SHALL proceed with the low 6 bits truncated.
REQ-031 Simultaneous FIFO write and read in one cycle SHALL leave occupancy unchanged.
REQ-032 Data read latency SHALL be at most 1 cycle from FIFO non-empty to mem_wr_data_valid.
REQ-033 Address arithmetic SHALL be ADDR_WIDTH wide with wrap-around; lengths are 32-bit unsigned.

Reset
REQ-034 Assertion of rst SHALL asynchronously force:
- FSM to IDLE;
- FIFO empty;
- all valid outputs, last, done and error to 0;
- almost_full to 0;
- stats to 0;
- the start edge detector to 0.
REQ-035 Reset mid-burst SHALL discard buffered data, with no partial command re-issued after release.

Configuration
REQ-036 With SGD_X_WB_STATS_EN defined:
- x_wb_stat_bursts counts command handshakes;
- x_wb_stat_lines counts accepted data beats;
- both are 32-bit wrapping counters.
REQ-037 Without SGD_X_WB_STATS_EN, both stats outputs SHALL be constant 0 and the counters SHALL not be synthesized.

Structure
REQ-038 Package sgd_x_wb_pkg SHALL hold LINE_BYTES=64, PAGE_BYTES=4096 and the FSM state enum typedef.
REQ-039 The data FIFO SHALL be the sub-module sgd_x_wb_fifo: synchronous, 512-bit wide, with occupancy count, full, empty and first-word-fall-through output.

Verification
REQ-040 Scenario 1:
- stimulus: start with addr=0x1000, len=256, 4 lines;
- response: one cmd (0x1000, 256), 4 beats with last on beat 4, one done pulse.
REQ-041 Scenario 2:
- stimulus: addr=0x1FC0, len=192;
- response: cmd (0x1FC0, 64) then cmd (0x2000, 128), lines in order.
REQ-042 Scenario 3:
- stimulus: len=8192 at addr 0, with mem_wr_data_ready toggled 50%;
- response: two 4096-byte cmds, 128 beats, no data loss, almost_full asserted once occupancy reaches 44.
REQ-043 Scenario 4:
- stimulus: len=0;
- response: no cmd, done pulse within 3 cycles.
REQ-044 Scenario 5:
- stimulus: second start edge mid-DATA;
- response: ignored, x_wb_error=1, first transfer completes normally.
REQ-045 Scenario 6:
- stimulus: rst asserted mid-DATA, then a new start with len=64;
- response: outputs clear immediately, FIFO empty, new transfer correct; stats = 1 burst/1 line with SGD_X_WB_STATS_EN defined, 0 without.

Source files
------------

// File: rtl/sgd_x_wb_pkg.sv
// Shared definitions for the X write-back burst writer.
//   LINE_BYTES : bytes per upstream data line (512 bits)
//   PAGE_BYTES : host page size; no burst may cross a page boundary
//   state_e    : burst-writer FSM states
package sgd_x_wb_pkg;
  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned PAGE_BYTES = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/sgd_x_wb_fifo.sv
// Synchronous first-word-fall-through line FIFO.
//   clk_i, rst_i      : clock, async active-high reset (empties the FIFO)
//   wr_en_i/wr_data_i : push; ignored while full
//   rd_en_i           : pop of the head line; ignored while empty
//   rd_data_o         : head line, valid whenever empty_o is low
//   count_o           : occupancy, 0 .. 2**DEPTH_BITS
//   full_o, empty_o   : status
module sgd_x_wb_fifo #(
  parameter int DEPTH_BITS = 6,
  parameter int WIDTH      = 512
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic [DEPTH_BITS:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);
  logic [WIDTH-1:0]      mem_q [2**DEPTH_BITS];
  logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_BITS:0]   count_q;
  logic                  do_wr, do_rd;

  // Occupancy never exceeds the depth, so its MSB alone marks full.
  assign full_o    = count_q[DEPTH_BITS];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/sgd_x_wb_burst_writer.sv
// Epoch write-back burst writer: buffers upstream 512-bit X lines and emits
// page-safe write bursts (command + data stream) to host memory.
//   clk, rst (async, active-high)
//   x_data_send_back_start/addr/length : epoch launch (rising edge of start)
//   x_data_out/_valid, x_data_out_almost_full : upstream line stream
//   mem_wr_cmd_*  : burst command handshake (byte address, byte length)
//   mem_wr_data_* : burst data stream, last on the final beat of a burst
//   x_wb_done (pulse), x_wb_error (sticky), x_wb_stat_* (counters)
// Optional feature: define SGD_X_WB_STATS_EN to build the statistics counters;
// otherwise the stats outputs are tied to zero.
module sgd_x_wb_burst_writer
  import sgd_x_wb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 64,
  parameter int FIFO_DEPTH_BITS = 6,
  parameter int AF_MARGIN       = 20,
  parameter int MAX_BURST_BYTES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         x_data_send_back_start,
  input  logic [63:0]  x_data_send_back_addr,
  input  logic [31:0]  x_data_send_back_length,
  input  logic [511:0] x_data_out,
  input  logic         x_data_out_valid,
  output logic         x_data_out_almost_full,
  output logic         mem_wr_cmd_valid,
  input  logic         mem_wr_cmd_ready,
  output logic [63:0]  mem_wr_cmd_addr,
  output logic [31:0]  mem_wr_cmd_len,
  output logic [511:0] mem_wr_data,
  output logic         mem_wr_data_valid,
  input  logic         mem_wr_data_ready,
  output logic         mem_wr_data_last,
  output logic         x_wb_done,
  output logic         x_wb_error,
  output logic [31:0]  x_wb_stat_bursts,
  output logic [31:0]  x_wb_stat_lines
);
  localparam logic [FIFO_DEPTH_BITS:0] AF_THRESH =
    (FIFO_DEPTH_BITS+1)'((1 << FIFO_DEPTH_BITS) - AF_MARGIN);

  state_e                  state_q, state_d;
  logic                    start_q, start_rise;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d, addr_in;
  logic [31:0]             remaining_q, remaining_d;
  logic [31:0]             burst_q, burst_d, burst_len, page_room;
  logic [6:0]              beats_q, beats_d;
  logic                    err_q, err_d, af_q;
  logic                    fifo_full, fifo_empty, beat_fire;
  logic [FIFO_DEPTH_BITS:0] fifo_count;

  sgd_x_wb_fifo #(.DEPTH_BITS(FIFO_DEPTH_BITS), .WIDTH(512)) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (x_data_out_valid),
    .wr_data_i (x_data_out),
    .rd_en_i   (beat_fire),
    .rd_data_o (mem_wr_data),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign start_rise = x_data_send_back_start & ~start_q;
  assign addr_in    = ADDR_WIDTH'(x_data_send_back_addr);

  // Burst = min(remaining, MAX_BURST_BYTES, bytes left in the current page).
  always_comb begin
    page_room = 32'(PAGE_BYTES) - {20'd0, cur_addr_q[11:0]};
    burst_len = remaining_q;
    if (burst_len > 32'(MAX_BURST_BYTES)) burst_len = 32'(MAX_BURST_BYTES);
    if (burst_len > page_room)            burst_len = page_room;
  end

  assign mem_wr_cmd_valid       = (state_q == CMD);
  assign mem_wr_cmd_addr        = 64'(cur_addr_q);
  assign mem_wr_cmd_len         = burst_len;
  assign mem_wr_data_valid      = (state_q == DATA) & ~fifo_empty;
  assign mem_wr_data_last       = mem_wr_data_valid & (beats_q == 7'd1);
  assign beat_fire              = mem_wr_data_valid & mem_wr_data_ready;
  assign x_wb_done              = (state_q == DONE);
  assign x_wb_error             = err_q;
  assign x_data_out_almost_full = af_q;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    burst_d     = burst_q;
    beats_d     = beats_q;
    err_d       = err_q;
    if (x_data_out_valid && fifo_full) err_d = 1'b1;  // line dropped
    case (state_q)
      IDLE: if (start_rise) begin
        // Misaligned inputs are flagged but still run, truncated to lines.
        cur_addr_d  = {addr_in[ADDR_WIDTH-1:6], 6'b0};
        remaining_d = {x_data_send_back_length[31:6], 6'b0};
        if ((|x_data_send_back_addr[5:0]) || (|x_data_send_back_length[5:0]))
          err_d = 1'b1;
        state_d = (x_data_send_back_length[31:6] == '0) ? DONE : CMD;
      end
      CMD: if (mem_wr_cmd_ready) begin
        burst_d = burst_len;
        beats_d = burst_len[12:6];  // burst is at most one page of lines
        state_d = DATA;
      end
      DATA: if (beat_fire) begin
        beats_d = beats_q - 7'd1;
        if (beats_q == 7'd1) begin
          cur_addr_d  = cur_addr_q + ADDR_WIDTH'(burst_q);
          remaining_d = remaining_q - burst_q;
          state_d     = (remaining_q == burst_q) ? DONE : CMD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start_rise && (state_q != IDLE)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      burst_q     <= '0;
      beats_q     <= '0;
      err_q       <= 1'b0;
      af_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= x_data_send_back_start;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      burst_q     <= burst_d;
      beats_q     <= beats_d;
      err_q       <= err_d;
      af_q        <= (fifo_count >= AF_THRESH);
    end
  end

`ifdef SGD_X_WB_STATS_EN
  logic [31:0] bursts_q, lines_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bursts_q <= '0;
      lines_q  <= '0;
    end else begin
      if (mem_wr_cmd_valid && mem_wr_cmd_ready) bursts_q <= bursts_q + 32'd1;
      if (beat_fire)                            lines_q  <= lines_q + 32'd1;
    end
  end
  assign x_wb_stat_bursts = bursts_q;
  assign x_wb_stat_lines  = lines_q;
`else
  assign x_wb_stat_bursts = '0;
  assign x_wb_stat_lines  = '0;
`endif
endmodule

// File: tb/tb_sgd_x_wb_burst_writer.sv
// Directed bench for sgd_x_wb_burst_writer with a command/data scoreboard.
module tb_sgd_x_wb_burst_writer;
  logic         clk, rst;
  logic         start;
  logic [63:0]  s_addr;
  logic [31:0]  s_len;
  logic [511:0] xd;
  logic         xd_valid, af;
  logic         cmd_valid, cmd_ready;
  logic [63:0]  cmd_addr;
  logic [31:0]  cmd_len;
  logic [511:0] wd;
  logic         wd_valid, wd_ready, wd_last;
  logic         done, err;
  logic [31:0]  st_bursts, st_lines;

  sgd_x_wb_burst_writer dut (
    .clk(clk), .rst(rst),
    .x_data_send_back_start(start), .x_data_send_back_addr(s_addr),
    .x_data_send_back_length(s_len),
    .x_data_out(xd), .x_data_out_valid(xd_valid), .x_data_out_almost_full(af),
    .mem_wr_cmd_valid(cmd_valid), .mem_wr_cmd_ready(cmd_ready),
    .mem_wr_cmd_addr(cmd_addr), .mem_wr_cmd_len(cmd_len),
    .mem_wr_data(wd), .mem_wr_data_valid(wd_valid), .mem_wr_data_ready(wd_ready),
    .mem_wr_data_last(wd_last), .x_wb_done(done), .x_wb_error(err),
    .x_wb_stat_bursts(st_bursts), .x_wb_stat_lines(st_lines)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [63:0] a; logic [31:0] l; } cmd_t;
  typedef struct { logic [511:0] d; logic last; } beat_t;
  cmd_t  cmd_q[$];
  beat_t data_q[$];
  cmd_t  mc;
  beat_t mb;

  int pass_cnt = 0, total_cnt = 0;
  int done_cnt = 0, beat_cnt = 0;
  bit rnd_ready = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (rnd_ready) wd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic kick(input logic [63:0] a, input logic [31:0] l);
    s_addr = a; s_len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic exp_cmd(input logic [63:0] a, input logic [31:0] l);
    cmd_t c;
    c.a = a; c.l = l;
    cmd_q.push_back(c);
  endtask

  task automatic drive_line(input logic last);
    beat_t b;
    for (int k = 0; k < 16; k++) b.d[k*32 +: 32] = $urandom;
    b.last = last;
    data_q.push_back(b);
    xd = b.d; xd_valid = 1'b1;
    tick();
    xd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin tick(); n++; end
    check(tag, 512'(done_cnt - d0), 512'(1));
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!wd_valid && n < budget) begin tick(); n++; end
  endtask

  // Scoreboard side: pop expectations on every accepted command / beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        if (cmd_q.size() == 0) check("cmd_unexpected", 512'(1), 512'(0));
        else begin
          mc = cmd_q.pop_front();
          check("cmd_addr", 512'(cmd_addr), 512'(mc.a));
          check("cmd_len",  512'(cmd_len),  512'(mc.l));
        end
      end
      if (wd_valid && wd_ready) begin
        beat_cnt++;
        if (data_q.size() == 0) check("beat_unexpected", 512'(1), 512'(0));
        else begin
          mb = data_q.pop_front();
          check("beat_data", wd, mb.d);
          check("beat_last", 512'(wd_last), 512'(mb.last));
        end
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    int b0;
    rst = 1'b1; start = 1'b0; s_addr = '0; s_len = '0;
    xd = '0; xd_valid = 1'b0; cmd_ready = 1'b0; wd_ready = 1'b0;
    #12;
    check("rst_cmd_valid", 512'(cmd_valid), 512'(0));
    check("rst_data_valid", 512'(wd_valid), 512'(0));
    check("rst_last", 512'(wd_last), 512'(0));
    check("rst_done", 512'(done), 512'(0));
    check("rst_error", 512'(err), 512'(0));
    check("rst_af", 512'(af), 512'(0));
    check("rst_stats", 512'({st_bursts, st_lines}), 512'(0));
    tick();
    rst = 1'b0;
    tick();

    // 1: single burst, data arrives during the command phase
    exp_cmd(64'h1000, 32'd256);
    kick(64'h1000, 32'd256);
    for (int i = 0; i < 4; i++) drive_line(i == 3);
    check("s1_hold_valid", 512'(cmd_valid), 512'(1));
    check("s1_hold_addr", 512'(cmd_addr), 512'(64'h1000));
    check("s1_hold_len", 512'(cmd_len), 512'(256));
    check("s1_no_data_in_cmd", 512'(wd_valid), 512'(0));
    cmd_ready = 1'b1; wd_ready = 1'b1;
    wait_done("s1_done", 50);
    check("s1_drained", 512'(cmd_q.size() + data_q.size()), 512'(0));

    // 2: page-crossing split, data buffered before the start
    exp_cmd(64'h1FC0, 32'd64);
    exp_cmd(64'h2000, 32'd128);
    drive_line(1'b1); drive_line(1'b0); drive_line(1'b1);
    kick(64'h1FC0, 32'd192);
    wait_done("s2_done", 50);
    check("s2_drained", 512'(cmd_q.size() + data_q.size()), 512'(0));

    // 3: 8 KB, random data ready, almost_full threshold at 44 lines
    for (int i = 0; i < 43; i++) drive_line(i % 64 == 63);
    tick(); tick();
    check("s3_af_at_43", 512'(af), 512'(0));
    drive_line(1'b0);
    tick(); tick();
    check("s3_af_at_44", 512'(af), 512'(1));
    exp_cmd(64'h0, 32'd4096);
    exp_cmd(64'h1000, 32'd4096);
    b0 = beat_cnt;
    rnd_ready = 1;
    kick(64'h0, 32'd8192);
    for (int i = 44; i < 128; i++) begin
      int w;
      w = 0;
      while (af && w < 200) begin tick(); w++; end
      drive_line(i % 64 == 63);
    end
    wait_done("s3_done", 2000);
    rnd_ready = 0; wd_ready = 1'b1;
    check("s3_beats", 512'(beat_cnt - b0), 512'(128));
    check("s3_drained", 512'(cmd_q.size() + data_q.size()), 512'(0));
    check("s3_no_error", 512'(err), 512'(0));

    // 4: zero length, done without any command
    kick(64'h3000, 32'd0);
    wait_done("s4_done", 2);
    check("s4_no_cmd", 512'(cmd_q.size()), 512'(0));

    // 5: second start while in DATA is ignored and flagged
    exp_cmd(64'h4000, 32'd128);
    wd_ready = 1'b0;
    kick(64'h4000, 32'd128);
    drive_line(1'b0); drive_line(1'b1);
    wait_valid(10);
    check("s5_in_data", 512'(wd_valid), 512'(1));
    check("s5_err_before", 512'(err), 512'(0));
    kick(64'h5000, 32'd64);
    check("s5_err_after", 512'(err), 512'(1));
    wd_ready = 1'b1;
    wait_done("s5_done", 50);
    check("s5_drained", 512'(cmd_q.size() + data_q.size()), 512'(0));
    tick(); tick();
    check("s5_single_done", 512'(done), 512'(0));

    // 6: reset mid-DATA, then a clean single-line transfer
    exp_cmd(64'h8000, 32'd256);
    wd_ready = 1'b0;
    kick(64'h8000, 32'd256);
    for (int i = 0; i < 4; i++) drive_line(i == 3);
    wait_valid(10);
    check("s6_in_data", 512'(wd_valid), 512'(1));
    #2 rst = 1'b1;
    #1;
    check("s6_rst_data_valid", 512'(wd_valid), 512'(0));
    check("s6_rst_cmd_valid", 512'(cmd_valid), 512'(0));
    check("s6_rst_error", 512'(err), 512'(0));
    check("s6_rst_af", 512'(af), 512'(0));
    cmd_q.delete(); data_q.delete();
    tick();
    rst = 1'b0; wd_ready = 1'b1;
    tick();
    exp_cmd(64'h9000, 32'd64);
    kick(64'h9000, 32'd64);
    tick();
    check("s6_fifo_empty", 512'(wd_valid), 512'(0));
    drive_line(1'b1);
    wait_done("s6_done", 50);
    check("s6_drained", 512'(cmd_q.size() + data_q.size()), 512'(0));
`ifdef SGD_X_WB_STATS_EN
    check("s6_stat_bursts", 512'(st_bursts), 512'(1));
    check("s6_stat_lines", 512'(st_lines), 512'(1));
`else
    check("s6_stat_bursts", 512'(st_bursts), 512'(0));
    check("s6_stat_lines", 512'(st_lines), 512'(0));
`endif
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
